// File: rtl/bit_deser_if.sv
// Bundles the serial-input and word-output handshake of the bit deserializer.
// The slave modport is the deserializer; the master modport is its environment.
interface bit_deser_if #(
    parameter int WIDTH = 8
);
    logic             bit_in;
    logic             bit_vld;
    logic             frame;
    logic [WIDTH-1:0] word_out;
    logic             word_vld;
    logic             word_rdy;
    logic             busy;
    logic             ovf;
    logic             sync_err;
    logic             flag_clr;

    modport master (
        output bit_in, bit_vld, frame, word_rdy, flag_clr,
        input  word_out, word_vld, busy, ovf, sync_err
    );

    modport slave (
        input  bit_in, bit_vld, frame, word_rdy, flag_clr,
        output word_out, word_vld, busy, ovf, sync_err
    );
endinterface

// File: rtl/bit_deser.sv
// Serial-to-parallel deserializer: packs qualified bits into WIDTH-bit words,
// realigned by an optional frame marker, behind a single-entry valid/ready slot.
module bit_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic        clk,
    input logic        rst,
    bit_deser_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] word_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             vld_q;
    logic             ovf_q;
    logic             serr_q;
    logic             accept;
    logic             restart;
    logic             complete;
    logic             slotFree;

    // Stale shift-register bits never need clearing: a full word's worth of shifts pushes them out.
    always_comb begin
        accept   = bus.bit_vld;
        restart  = accept && bus.frame && (cnt_q != '0);
        complete = accept && !bus.frame && (cnt_q == LAST);
        slotFree = !vld_q || bus.word_rdy;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        if (accept) begin
            if (MSB_FIRST) begin
                sh_d = {sh_q[WIDTH-2:0], bus.bit_in};
            end else begin
                sh_d = {bus.bit_in, sh_q[WIDTH-1:1]};
            end
            if (bus.frame) begin
                cnt_d = CW'(1);
            end else if (complete) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            case (state_q)
                IDLE: if (accept)   state_q <= FILL;
                FILL: if (complete) state_q <= IDLE;
            endcase
            // On completion the shifted value is exactly the assembled word.
            if (complete && slotFree) begin
                word_q <= sh_d;
                vld_q  <= 1'b1;
            end else if (bus.word_rdy) begin
                vld_q  <= 1'b0;
            end
            ovf_q  <= (complete && !slotFree) || (ovf_q && !bus.flag_clr);
            serr_q <= restart || (serr_q && !bus.flag_clr);
        end
    end

    assign bus.word_out = word_q;
    assign bus.word_vld = vld_q;
    assign bus.busy     = (state_q == FILL);
    assign bus.ovf      = ovf_q;
    assign bus.sync_err = serr_q;
endmodule

// File: tb/tb_bit_deser.sv
// Directed bench for bit_deser: an MSB-first and an LSB-first instance share one
// bit stream; a vector table plus hand sequences cover reset, overflow and resync.
module tb_bit_deser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bitIn = 1'b0;
    logic       bitVld = 1'b0;
    logic       frameIn = 1'b0;
    logic       wordRdy = 1'b0;
    logic       flagClr = 1'b0;
    int         vecCount = 0;
    int         missCount = 0;

    bit_deser_if #(.WIDTH(8)) busM ();
    bit_deser_if #(.WIDTH(8)) busL ();

    assign busM.bit_in   = bitIn;
    assign busM.bit_vld  = bitVld;
    assign busM.frame    = frameIn;
    assign busM.word_rdy = wordRdy;
    assign busM.flag_clr = flagClr;
    assign busL.bit_in   = bitIn;
    assign busL.bit_vld  = bitVld;
    assign busL.frame    = frameIn;
    assign busL.word_rdy = wordRdy;
    assign busL.flag_clr = flagClr;

    bit_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (.clk(clk), .rst(rst), .bus(busM));
    bit_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (.clk(clk), .rst(rst), .bus(busL));

    always #5 clk = ~clk;

    typedef struct {
        logic       bitIn;
        logic       bitVld;
        logic       frame;
        logic       wordRdy;
        logic       flagClr;
        logic [7:0] expWo;
        logic       expVld;
        logic       expBusy;
        logic       expOvf;
        logic       expSe;
        logic [7:0] expWoL;
    } vec_t;

    vec_t vecs[$];

    // One cycle: drive inputs in the low phase, let the rising edge act, return at the next falling edge.
    task automatic applyStimulus(input logic bi, input logic bv, input logic fr,
                                 input logic rd, input logic cl);
        bitIn   = bi;
        bitVld  = bv;
        frameIn = fr;
        wordRdy = rd;
        flagClr = cl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmpField(input string name, input string field,
                            input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s %s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] wo, input logic vld,
                               input logic bsy, input logic ov, input logic se,
                               input logic [7:0] woL);
        vecCount++;
        cmpField(name, "word_out",   busM.word_out,        wo);
        cmpField(name, "word_vld",   {7'd0, busM.word_vld}, {7'd0, vld});
        cmpField(name, "busy",       {7'd0, busM.busy},     {7'd0, bsy});
        cmpField(name, "ovf",        {7'd0, busM.ovf},      {7'd0, ov});
        cmpField(name, "sync_err",   {7'd0, busM.sync_err}, {7'd0, se});
        cmpField(name, "lsb_word",   busL.word_out,        woL);
        cmpField(name, "lsb_vld",    {7'd0, busL.word_vld}, {7'd0, vld});
    endtask

    task automatic pushVec(input logic bi, input logic bv, input logic fr, input logic rd,
                           input logic cl, input logic [7:0] wo, input logic vld,
                           input logic bsy, input logic ov, input logic se, input logic [7:0] woL);
        vecs.push_back('{bi, bv, fr, rd, cl, wo, vld, bsy, ov, se, woL});
    endtask

    // Mid-word bits first..first+n-1 of w (MSB first); busy is expected high throughout.
    task automatic addFill(input logic [7:0] w, input int first, input int n, input logic fr,
                           input logic rd, input logic [7:0] wo, input logic vld,
                           input logic ov, input logic se, input logic [7:0] woL);
        for (int i = first; i < first + n; i++)
            pushVec(w[7-i], 1'b1, fr && (i == first), rd, 1'b0, wo, vld, 1'b1, ov, se, woL);
    endtask

    task automatic sendBits(input logic [7:0] w, input int n, input logic fr, input logic rd);
        for (int i = 0; i < n; i++)
            applyStimulus(w[7-i], 1'b1, fr && (i == 0), rd, 1'b0);
    endtask

    initial begin
        // Basic word 0xA6 with a frame-ignored stall in the middle.
        addFill(8'hA6, 0, 4, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        pushVec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        addFill(8'hA6, 4, 3, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        pushVec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h65);
        pushVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h65);
        // Overflow: 0xA6 held, 0x3C dropped, then drain and clear.
        addFill(8'hA6, 0, 7, 1'b1, 1'b0, 8'hA6, 1'b0, 1'b0, 1'b0, 8'h65);
        pushVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h65);
        addFill(8'h3C, 0, 7, 1'b1, 1'b0, 8'hA6, 1'b1, 1'b0, 1'b0, 8'h65);
        pushVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA6, 1'b1, 1'b0, 1'b1, 1'b0, 8'h65);
        pushVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA6, 1'b0, 1'b0, 1'b1, 1'b0, 8'h65);
        pushVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h65);
        // Resync: three bits, then a frame restarts on 0x5A.
        addFill(8'hE0, 0, 3, 1'b1, 1'b1, 8'hA6, 1'b0, 1'b0, 1'b0, 8'h65);
        addFill(8'h5A, 0, 1, 1'b1, 1'b1, 8'hA6, 1'b0, 1'b0, 1'b1, 8'h65);
        addFill(8'h5A, 1, 6, 1'b0, 1'b1, 8'hA6, 1'b0, 1'b0, 1'b1, 8'h65);
        pushVec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
        pushVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
        // 0x11 pending; 0x22 completes on the same edge it is taken.
        addFill(8'h11, 0, 7, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A);
        pushVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h88);
        addFill(8'h22, 0, 7, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h88);
        pushVec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
        pushVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44);

        #1 rst = 1'b0;
        #2 checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].bitIn, vecs[i].bitVld, vecs[i].frame,
                          vecs[i].wordRdy, vecs[i].flagClr);
            checkOutput($sformatf("vec%0d", i), vecs[i].expWo, vecs[i].expVld,
                        vecs[i].expBusy, vecs[i].expOvf, vecs[i].expSe, vecs[i].expWoL);
        end

        // Asynchronous reset after 5 of 8 bits, with no clock edge in between.
        sendBits(8'hF0, 5, 1'b1, 1'b0);
        checkOutput("partial", 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44);
        #2 rst = 1'b0;
        bitVld = 1'b0;
        #1 checkOutput("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        sendBits(8'hF0, 7, 1'b0, 1'b0);
        checkOutput("fresh_fill", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("fresh_F0", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);

        // Flag set beats flag_clr on the same edge.
        sendBits(8'h00, 7, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_set_wins", 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0F);
        sendBits(8'hC0, 2, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("serr_set_wins", 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("final_clear", 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
